npu_layer_sequencer: RTL and testbench

Control block that time-shares one 4-input neuron datapath (`nn_accelerator`: signed 8-bit weight0..3/input0..3 in, signed 16-bit `output_neuron` out) across all neurons of a fully-connected layer. It stores up to NUM_NEURONS packed weight rows and one shared 4-element input vector. On `start` it drives each weight row plus the input vector into the accelerator, waits the accelerator latency, captures the sum, applies optional ReLU and streams one result per neuron over a valid/ready port. It sits between the host load path and the accelerator instance.

---
 rtl/npu_layer_sequencer.sv | 166 ++++++++++++++++
 tb/tb_npu_layer_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer
// Time-shares one 4-input neuron datapath (nn_accelerator) across every
// neuron of a fully-connected layer. Holds NUM_NEURONS packed weight rows
// plus one shared input vector, issues one row at a time to the
// accelerator, captures its sum after ACC_LATENCY cycles, applies optional
// ReLU and streams one result per neuron over a valid/ready port.
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   cfg_we/cfg_addr/cfg_wdata  weight-row write (IDLE only)
//   in_we/in_wdata         shared input-vector write (IDLE only)
//   layer_len, relu_en     run configuration, sampled on start
//   start                  start pulse (IDLE only)
//   busy, done             run status / one-cycle completion pulse
//   weight0..3, input0..3  registered operands to the accelerator
//   output_neuron          accelerator sum
//   res_valid/res_ready    result handshake
//   res_data/res_idx/res_last  result, its neuron index, final-neuron flag
module npu_layer_sequencer #(
  parameter int NUM_NEURONS = 8,
  parameter int ACC_LATENCY = 1,
  parameter int AW          = $clog2(NUM_NEURONS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [31:0]       cfg_wdata,
  input  logic              in_we,
  input  logic [31:0]       in_wdata,
  input  logic [AW:0]       layer_len,
  input  logic              relu_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        weight0,
  output logic [7:0]        weight1,
  output logic [7:0]        weight2,
  output logic [7:0]        weight3,
  output logic [7:0]        input0,
  output logic [7:0]        input1,
  output logic [7:0]        input2,
  output logic [7:0]        input3,
  input  logic [15:0]       output_neuron,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic [AW-1:0]     res_idx,
  output logic              res_last
);

  localparam int CW = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(ACC_LATENCY - 1);
  localparam logic [AW:0]   MAX_LEN  = (AW+1)'(NUM_NEURONS);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_FINISH} state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            rows_reg [NUM_NEURONS];
  logic [31:0]            in_vec_reg;
  logic [NUM_NEURONS-1:0] row_we;
  logic [AW:0]            len_reg;
  logic                   relu_reg;
  logic [AW-1:0]          idx_reg;
  logic [CW-1:0]          cnt_reg;
  logic [31:0]            w_reg, x_reg;
  logic [15:0]            res_data_reg;
  logic [AW:0]            start_len;
  logic                   last_idx;

  // Oversized layers are clamped to the storage depth.
  assign start_len = (layer_len > MAX_LEN) ? MAX_LEN : layer_len;
  assign last_idx  = ({1'b0, idx_reg} == (len_reg - 1'b1));

  // Row write decode: storage only changes while idle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_row_we
      assign row_we[gi] = (state_reg == S_IDLE) && cfg_we && (cfg_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) rows_reg[i] <= '0;
      in_vec_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++)
        if (row_we[i]) rows_reg[i] <= cfg_wdata;
      if (state_reg == S_IDLE && in_we) in_vec_reg <= in_wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = (start_len == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:  state_next = S_WAIT;
      S_WAIT:   if (cnt_reg == LAT_LAST) state_next = S_OUT;
      S_OUT:    if (res_ready) state_next = last_idx ? S_FINISH : S_ISSUE;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_reg      <= '0;
      relu_reg     <= 1'b0;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      w_reg        <= '0;
      x_reg        <= '0;
      res_data_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          len_reg  <= start_len;
          relu_reg <= relu_en;
          idx_reg  <= '0;
        end
        S_ISSUE: begin
          w_reg   <= rows_reg[idx_reg];
          x_reg   <= in_vec_reg;
          cnt_reg <= '0;
        end
        S_WAIT: begin
          if (cnt_reg == LAT_LAST)
            res_data_reg <= (relu_reg && output_neuron[15]) ? 16'd0 : output_neuron;
          else
            cnt_reg <= cnt_reg + 1'b1;
        end
        S_OUT: if (res_ready && !last_idx) idx_reg <= idx_reg + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy      = (state_reg == S_ISSUE) || (state_reg == S_WAIT) || (state_reg == S_OUT);
    done      = (state_reg == S_FINISH);
    res_valid = (state_reg == S_OUT);
    res_last  = (state_reg == S_OUT) && last_idx;
  end

  assign res_data = res_data_reg;
  assign res_idx  = idx_reg;
  assign weight0  = w_reg[7:0];
  assign weight1  = w_reg[15:8];
  assign weight2  = w_reg[23:16];
  assign weight3  = w_reg[31:24];
  assign input0   = x_reg[7:0];
  assign input1   = x_reg[15:8];
  assign input2   = x_reg[23:16];
  assign input3   = x_reg[31:24];

endmodule

// File: tb/tb_npu_layer_sequencer.sv
module tb_npu_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset, reset3, cfg_we, in_we, start, start3, relu_en, res_ready;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata, in_wdata;
  logic [3:0]  layer_len;

  logic        busy, done, res_valid, res_last;
  logic [15:0] res_data, output_neuron;
  logic [2:0]  res_idx;
  logic [7:0]  w0, w1, w2, w3, i0, i1, i2, i3;

  logic        busy3, done3, res_valid3, res_last3;
  logic [15:0] res_data3, output_neuron3, p1, p2;
  logic [2:0]  res_idx3;
  logic [7:0]  v0, v1, v2, v3, j0, j1, j2, j3;

  int compared = 0;
  int mismatched = 0;
  logic sel3 = 1'b0;

  logic [31:0] model_rows [8];
  logic [31:0] model_in;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  npu_layer_sequencer #(.NUM_NEURONS(8), .ACC_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_we(in_we), .in_wdata(in_wdata), .layer_len(layer_len), .relu_en(relu_en),
    .start(start), .busy(busy), .done(done),
    .weight0(w0), .weight1(w1), .weight2(w2), .weight3(w3),
    .input0(i0), .input1(i1), .input2(i2), .input3(i3),
    .output_neuron(output_neuron), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last));

  npu_layer_sequencer #(.NUM_NEURONS(8), .ACC_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset3), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .in_we(in_we), .in_wdata(in_wdata), .layer_len(layer_len), .relu_en(relu_en),
    .start(start3), .busy(busy3), .done(done3),
    .weight0(v0), .weight1(v1), .weight2(v2), .weight3(v3),
    .input0(j0), .input1(j1), .input2(j2), .input3(j3),
    .output_neuron(output_neuron3), .res_valid(res_valid3), .res_ready(res_ready),
    .res_data(res_data3), .res_idx(res_idx3), .res_last(res_last3));

  // Behavioural 4-input neuron: signed dot product wrapped to 16 bits.
  function automatic logic [15:0] dot4(input logic [7:0] a0, a1, a2, a3,
                                       input logic [7:0] b0, b1, b2, b3);
    int s;
    s = int'($signed(a0)) * int'($signed(b0)) + int'($signed(a1)) * int'($signed(b1)) +
        int'($signed(a2)) * int'($signed(b2)) + int'($signed(a3)) * int'($signed(b3));
    return 16'(s);
  endfunction

  // Latency-1 accelerator is combinational; latency-3 has two pipeline stages.
  assign output_neuron = dot4(w0, w1, w2, w3, i0, i1, i2, i3);
  always @(posedge clk) begin
    p1 <= dot4(v0, v1, v2, v3, j0, j1, j2, j3);
    p2 <= p1;
  end
  assign output_neuron3 = p2;

  logic        m_valid, m_last, m_done, m_busy;
  logic [15:0] m_data;
  logic [2:0]  m_idx;
  always_comb begin
    m_valid = sel3 ? res_valid3 : res_valid;
    m_last  = sel3 ? res_last3  : res_last;
    m_done  = sel3 ? done3      : done;
    m_busy  = sel3 ? busy3      : busy;
    m_data  = sel3 ? res_data3  : res_data;
    m_idx   = sel3 ? res_idx3   : res_idx;
  end

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [15:0] expect_res(input logic [31:0] w, input logic [31:0] x, input bit relu);
    logic [15:0] d;
    d = dot4(w[7:0], w[15:8], w[23:16], w[31:24], x[7:0], x[15:8], x[23:16], x[31:24]);
    if (relu && d[15]) d = 16'd0;
    return d;
  endfunction

  task automatic write_row(input int a, input logic [31:0] w);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = w;
    @(negedge clk); cfg_we = 1'b0;
    model_rows[a] = w;
  endtask

  task automatic write_in(input logic [31:0] x);
    @(negedge clk); in_we = 1'b1; in_wdata = x;
    @(negedge clk); in_we = 1'b0;
    model_in = x;
  endtask

  // Runs one layer on the selected DUT, scoreboarding every transfer.
  task automatic run_layer(input string name, input int n, input bit relu, input bit rnd,
                           input bit junk, input int exp_period);
    int eff, cyc, first_rise, last_rise, last_xfer, lat;
    bit got_done, prev_stall, prev_valid;
    logic [15:0] hold_data;
    logic [2:0]  hold_idx;
    logic        hold_last;
    exp_t e;
    eff = (n > 8) ? 8 : n;
    lat = sel3 ? 3 : 1;
    for (int k = 0; k < eff; k++)
      sb.push_back('{data: expect_res(model_rows[k], model_in, relu), idx: 3'(k), last: (k == eff - 1)});
    @(negedge clk);
    layer_len = 4'(n); relu_en = relu;
    if (sel3) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start3 = 1'b0;
    cyc = 0; got_done = 0; prev_stall = 0; prev_valid = 0;
    first_rise = -1; last_rise = -1; last_xfer = -1;
    hold_data = '0; hold_idx = '0; hold_last = 1'b0;
    while (!got_done && cyc < 3000) begin
      if (cyc > 0) @(negedge clk);
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk && cyc < 4) begin
        cfg_we = 1'b1; cfg_addr = 3'(cyc); cfg_wdata = $urandom;
        in_we = 1'b1; in_wdata = $urandom; start = 1'b1; layer_len = 4'd1;
      end else if (junk) begin
        cfg_we = 1'b0; in_we = 1'b0; start = 1'b0;
      end
      #1;
      if (cyc == 0) begin
        compared++;
        if (m_busy !== (eff > 0)) begin
          mismatched++; $display("FAIL %s.busy_after_start: got %b expected %b", name, m_busy, eff > 0);
        end
      end
      if (prev_stall) begin
        compared++;
        if (m_valid !== 1'b1 || m_data !== hold_data || m_idx !== hold_idx || m_last !== hold_last) begin
          mismatched++;
          $display("FAIL %s.stall_stable: got v=%b d=%h i=%0d l=%b expected v=1 d=%h i=%0d l=%b",
                   name, m_valid, m_data, m_idx, m_last, hold_data, hold_idx, hold_last);
        end
      end
      if (m_valid && !prev_valid) begin
        if (first_rise < 0) first_rise = cyc;
        else if (exp_period > 0) begin
          compared++;
          if (cyc - last_rise != exp_period) begin
            mismatched++; $display("FAIL %s.period: got %0d expected %0d", name, cyc - last_rise, exp_period);
          end
        end
        last_rise = cyc;
      end
      if (m_valid && res_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++; $display("FAIL %s.extra_result: got d=%h i=%0d expected no result", name, m_data, m_idx);
        end else begin
          e = sb.pop_front();
          if (m_data !== e.data || m_idx !== e.idx || m_last !== e.last) begin
            mismatched++;
            $display("FAIL %s.result: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                     name, m_data, m_idx, m_last, e.data, e.idx, e.last);
          end
        end
        last_xfer = cyc;
      end
      if (m_done) begin
        got_done = 1;
        compared++;
        if (m_busy !== 1'b0 || sb.size() != 0 ||
            (eff > 0 && cyc != last_xfer + 1) || (eff == 0 && cyc > 1)) begin
          mismatched++;
          $display("FAIL %s.done: got busy=%b pending=%0d cyc=%0d expected busy=0 pending=0 cyc=%0d",
                   name, m_busy, sb.size(), cyc, (eff > 0) ? last_xfer + 1 : 0);
        end
      end
      prev_stall = m_valid && !res_ready;
      prev_valid = m_valid;
      hold_data = m_data; hold_idx = m_idx; hold_last = m_last;
      cyc++;
    end
    cfg_we = 1'b0; in_we = 1'b0; start = 1'b0;
    if (!got_done) begin
      mismatched++; compared++;
      $display("FAIL %s.timeout: got no done expected done within 3000 cycles", name);
      sb.delete();
    end
    if (eff > 0) begin
      compared++;
      if (first_rise != lat + 1) begin
        mismatched++; $display("FAIL %s.first_latency: got %0d expected %0d", name, first_rise, lat + 1);
      end
    end
    @(negedge clk); #1;
    compared++;
    if (m_done !== 1'b0 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
      mismatched++; $display("FAIL %s.after_done: got done=%b busy=%b valid=%b expected 0 0 0", name, m_done, m_busy, m_valid);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; reset3 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      start = ~start; cfg_we = ~cfg_we; cfg_addr = 3'(c); cfg_wdata = $urandom;
      in_we = 1'b1; in_wdata = $urandom; layer_len = 4'd3;
      #1;
      compared++;
      if (res_valid !== 1'b0 || done !== 1'b0) begin
        mismatched++; $display("FAIL reset.quiet: got valid=%b done=%b expected 0 0", res_valid, done);
      end
    end
    @(negedge clk); #1;
    compared++;
    if ({busy, done, res_valid, res_last, res_data, res_idx, w0, w1, w2, w3, i0, i1, i2, i3} !== '0) begin
      mismatched++;
      $display("FAIL reset.outputs: got b=%b d=%b v=%b l=%b data=%h idx=%0d w=%h%h%h%h x=%h%h%h%h expected all 0",
               busy, done, res_valid, res_last, res_data, res_idx, w3, w2, w1, w0, i3, i2, i1, i0);
    end
    start = 1'b0; cfg_we = 1'b0; in_we = 1'b0;
    reset = 1'b1; reset3 = 1'b1;
    for (int k = 0; k < 8; k++) model_rows[k] = '0;
    model_in = '0;
    // Storage must have been cleared by reset.
    run_layer("reset_storage", 2, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_single();
    write_row(0, pack(2, -1, 5, 1));
    write_in(pack(3, 4, -2, 6));
    run_layer("single", 1, 1'b0, 1'b0, 1'b0, 0);
    compared++;
    if ({w3, w2, w1, w0} !== model_rows[0] || {i3, i2, i1, i0} !== model_in) begin
      mismatched++;
      $display("FAIL single.operand_hold: got w=%h x=%h expected w=%h x=%h",
               {w3, w2, w1, w0}, {i3, i2, i1, i0}, model_rows[0], model_in);
    end
  endtask

  task automatic test_relu();
    run_layer("relu_neg", 1, 1'b1, 1'b0, 1'b0, 0);
    write_row(0, pack(2, 1, 5, 1));
    run_layer("relu_pos", 1, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    write_row(0, pack(1, 1, 1, 1));
    write_row(1, pack(-1, 0, 0, 0));
    write_row(2, pack(127, 127, 127, 127));
    write_in(pack(-128, -128, -128, -128));
    run_layer("backpressure", 3, 1'b0, 1'b1, 1'b0, 0);
    run_layer("backpressure_relu", 3, 1'b1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_ignored();
    run_layer("ignored_busy", 2, 1'b0, 1'b1, 1'b1, 0);
    run_layer("ignored_rerun", 3, 1'b0, 1'b0, 1'b0, 3);
    run_layer("len_zero", 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_clamp();
    for (int k = 0; k < 8; k++) write_row(k, pack(k + 1, -k, 3 * k - 7, 2));
    write_in(pack(5, -3, 9, -20));
    run_layer("clamp", 15, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_latency_abort();
    sel3 = 1'b1;
    write_row(0, pack(10, -20, 30, -40));
    write_row(1, pack(-7, 8, 9, 100));
    write_in(pack(1, 2, 3, 4));
    run_layer("lat3", 2, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk); layer_len = 4'd2; start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    @(negedge clk); reset3 = 1'b0;
    @(negedge clk); reset3 = 1'b1;
    #1;
    compared++;
    if (busy3 !== 1'b0 || res_valid3 !== 1'b0 || done3 !== 1'b0) begin
      mismatched++; $display("FAIL abort.idle: got busy=%b valid=%b done=%b expected 0 0 0", busy3, res_valid3, done3);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      compared++;
      if (done3 !== 1'b0 || res_valid3 !== 1'b0) begin
        mismatched++; $display("FAIL abort.quiet: got done=%b valid=%b expected 0 0", done3, res_valid3);
      end
    end
    // Reset cleared storage, so reload before the recovery run.
    write_row(0, pack(10, -20, 30, -40));
    write_row(1, pack(-7, 8, 9, 100));
    write_in(pack(1, 2, 3, 4));
    run_layer("after_abort", 2, 1'b1, 1'b1, 1'b0, 0);
    sel3 = 1'b0;
  endtask

  initial begin
    reset = 1'b0; reset3 = 1'b0; cfg_we = 1'b0; in_we = 1'b0; start = 1'b0; start3 = 1'b0;
    relu_en = 1'b0; res_ready = 1'b0; cfg_addr = '0; cfg_wdata = '0; in_wdata = '0; layer_len = '0;
    test_reset();
    test_single();
    test_relu();
    test_backpressure();
    test_ignored();
    test_clamp();
    test_latency_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
